// File: rtl/transrf_wr_sched.sv
// transrf_wr_sched
//   Write-side scheduler for the transposing register file. Several nibble-stream
//   requesters share the file's single serial write port. Each grant covers one
//   whole GLEN-nibble group, so groups from different sources never interleave.
//   Requesters are served round-robin. No new group starts while rf_full is high.
//
// Ports
//   clk_w       write clock; all logic on its rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester nibble available
//   req_data    per-requester nibble, requester i at [i*DW +: DW]
//   req_ready   per-requester consume strobe; decoded from registered state only
//   rf_full     register file full flag, sampled only while idle
//   w_en        registered write enable to the register file
//   w_data      registered write data to the register file
//   grant_id    current or most recent granted requester
//   busy        a group is in progress (BURST or SETTLE)
//   group_done  one-cycle pulse alongside the last w_en of a group
//   group_cnt   completed group count, wraps at 16 bits
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for rf_full=0 and any valid requester; arbitrates
// BURST  | granted requester streams GLEN nibbles; bubbles are tolerated
// SETTLE | one dead cycle so rf_full reflects the last write before rearbitration
module transrf_wr_sched #(
  parameter int          NREQ     = 4,
  parameter int          GLEN     = 5,
  parameter int          DW       = 4,
  // Reset value of group_cnt; normally 0.
  parameter logic [15:0] CNT_INIT = 16'h0000,
  localparam int         IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_w,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 rf_full,
  output logic                 w_en,
  output logic [DW-1:0]        w_data,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 group_done,
  output logic [15:0]          group_cnt
);

  localparam int BW = (GLEN > 1) ? $clog2(GLEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BURST  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BW-1:0]   r_beat_cnt;
  logic [IDW-1:0]  r_rr_ptr;

  logic [IDW-1:0]  w_pick;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_xfer;
  logic            w_last;
  logic            w_start;
  logic [DW-1:0]   w_nib;

  // Cyclic search from r_rr_ptr. Walking the offsets downwards lets the
  // smallest offset with a valid request overwrite the others.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_pick = w_idx;
      end
    end
  end

  assign w_any = |req_valid;

  // Ready is a pure function of registered state, so there is no valid->ready path.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_state == S_BURST && grant_id == IDW'(i)) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_nib = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        w_nib = req_data[i*DW +: DW];
      end
    end
  end

  // req_ready is one-hot on the grant during BURST, so this is the granted valid.
  assign w_xfer = |(req_valid & req_ready);
  assign w_last = w_xfer && (r_beat_cnt == BW'(GLEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rf_full && w_any) begin
          w_state_nxt = S_BURST;
          w_start     = 1'b1;
        end
      end
      S_BURST: begin
        if (w_last) begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_rr_ptr   <= '0;
      grant_id   <= '0;
      w_en       <= 1'b0;
      w_data     <= '0;
      group_done <= 1'b0;
      group_cnt  <= CNT_INIT;
    end else begin
      r_state    <= w_state_nxt;
      w_en       <= w_xfer;
      group_done <= w_last;
      if (w_xfer) begin
        w_data     <= w_nib;
        r_beat_cnt <= r_beat_cnt + BW'(1);
      end
      if (w_start) begin
        grant_id   <= w_pick;
        r_beat_cnt <= '0;
      end
      if (w_last) begin
        group_cnt <= group_cnt + 16'd1;
        r_rr_ptr  <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
    end
  end

endmodule

// File: doc/transrf_wr_sched.md
# transrf_wr_sched

Write-side scheduler for the 4-bit-in / 20-bit-out transposing register file (5 nibbles per group, 3 groups). It shares the register file's single serial write port between `NREQ` nibble-stream requesters. Each grant is one complete 5-nibble group, so a group is never interleaved across sources. Requesters are served round-robin, and no new group starts while the register file reports full.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, range 2..8.
- `GLEN`, default 5: nibbles per group; must match the register file row count.
- `DW`, default 4: nibble width.

Ports:
- `clk_w` in 1: write clock; all logic is posedge `clk_w`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NREQ`: requester i has a nibble available.
- `req_data` in `NREQ*DW`: requester i data at bits `[i*DW +: DW]`.
- `req_ready` out `NREQ`: requester i's nibble is consumed this cycle.
- `rf_full` in 1: full flag from the register file.
- `w_en` out 1: register file write enable, registered.
- `w_data` out `DW`: register file write data, registered.
- `grant_id` out `clog2(NREQ)`: current or last granted requester.
- `busy` out 1: a group is in progress (state BURST or SETTLE).
- `group_done` out 1: one-cycle pulse coincident with a group's last `w_en`.
- `group_cnt` out 16: number of completed groups, wraps.

## Operation
- State machine:
  - **IDLE**: if `rf_full`=0 and any `req_valid`, select the first valid requester at or after `rr_ptr` (cyclic search). Load `grant_id`, clear `beat_cnt`, go to BURST. Otherwise stay in IDLE.
  - **BURST**: `req_ready[grant_id]`=1; all other `req_ready` bits are 0. A transfer occurs when the granted `req_valid`=1. On each transfer `beat_cnt` increments. On the transfer where `beat_cnt`=`GLEN`-1, go to SETTLE.
  - **SETTLE**: one cycle with `req_ready`=0. Lets `rf_full` reflect the last write before the next arbitration. Then go to IDLE.
- `req_ready` is decoded combinationally from registered state only (no valid-to-ready path).
- A bubble (granted `req_valid`=0) in BURST inserts a `w_en`=0 cycle. The grant is held; there is no timeout and no regrant until `GLEN` beats complete.
- `rr_ptr` is updated to `grant_id`+1 (mod `NREQ`) in the cycle the last beat transfers. `rr_ptr` resets to 0.
- `rf_full` is checked only in IDLE. An assertion during BURST is ignored: the group in progress always completes.
- Requesters must not withdraw data mid-group. Withdrawal is not detected; the scheduler only counts beats.
- `group_cnt` increments by 1 with `group_done` and wraps from 0xFFFF to 0.
- Reset mid-group abandons the partial group. The register file shares `rst_n`, so its state is consistent.
- Reset values: `w_en`=0, `w_data`=0, `req_ready`=0, `grant_id`=0, `busy`=0, `group_done`=0, `group_cnt`=0, `rr_ptr`=0, state IDLE.

## Timing
- Transfer in cycle t produces `w_en`=1 and `w_data`=that nibble in cycle t+1: one-cycle latency.
- Arbitration takes one cycle: valid seen in IDLE at cycle t, first `req_ready` at t+1.
- Back-to-back groups with all inputs continuously valid: 1 IDLE + `GLEN` BURST + 1 SETTLE = 7 cycles per group; `w_en` duty is 5/7.
- `group_done` is asserted in the same cycle as the 5th `w_en`.
- `rf_full` is sampled in IDLE, two cycles after the last transfer, i.e. one cycle after the last `w_en`.

## Test plan
- Single requester: req 0 streams 1,2,3,4,5 with valid held high from reset release.
  - `w_en` is high for 5 consecutive cycles with `w_data` 1..5.
  - `group_done` is asserted on the 5th `w_en`.
  - `group_cnt`=1.
- Round-robin: req 0 and req 2 both valid continuously.
  - Groups alternate 0,2,0,2; `grant_id` matches.
  - Each group has 5 contiguous `w_en`; gaps between groups are exactly 2 cycles.
- Mid-burst bubble: req 1 drops valid for 3 cycles after beat 2.
  - `w_en` shows a 3-cycle hole.
  - Grant is held; the remaining beats 3..5 follow.
  - No other requester is granted meanwhile.
- Full back-pressure: `rf_full`=1 with req 0 valid.
  - `req_ready` stays 0 and `w_en` stays 0.
  - After `rf_full` falls, the first `req_ready` appears exactly 1 cycle later.
  - `rf_full` rising during BURST does not stop the group.
- Reset mid-group: `rst_n` pulsed low after beat 3.
  - All outputs return to reset values immediately.
  - After release, a fresh group of 5 is written, starting from req 0 priority.
- Counter wrap: force `group_cnt` to 0xFFFF (or preload in simulation), then complete one group.
  - `group_cnt` becomes 0.
